// File: rtl/tcpu_pkg.sv
// tcpu_pkg: shared definitions for the tiny-cpu memory subsystem.
//   DATA_W_DEF / ADDR_W_DEF : default word width and implemented address bits
//   MAX_PORTS               : largest requester count the index type can encode
//   state_t                 : arbiter sequencer states (IDLE, ACCESS, DONE)
//   port_idx_t              : encoded requester index
package tcpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int MAX_PORTS  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [2:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req       in  NUM_PORTS  request vector
//   last      in  idx        most recent winner; search starts at last+1
//   grant     out NUM_PORTS  one-hot winner (all zero when req == 0)
//   grant_idx out idx        encoded winner (0 when req == 0)
module rr_arbiter
  import tcpu_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            last,
  output logic [NUM_PORTS-1:0] grant,
  output port_idx_t            grant_idx
);

  logic found;

  // Two passes implement the wrap: ports above last first, then 0..last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!found && req[p] && (p > int'(last))) begin
        found     = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = port_idx_t'(p);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!found && req[p] && (p <= int'(last))) begin
        found     = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = port_idx_t'(p);
      end
    end
  end

endmodule

// File: rtl/tcpu_mem_arbiter.sv
// tcpu_mem_arbiter: shared data/instruction memory with a round-robin
// front end. One access is serviced at a time via IDLE -> ACCESS -> DONE.
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   req      in   NUM_PORTS         level request, held until ack
//   we       in   NUM_PORTS         1 = store
//   addr     in   NUM_PORTS x DATA_W word address
//   wdata    in   NUM_PORTS x DATA_W store data
//   ack      out  NUM_PORTS         one-hot, one-cycle completion pulse
//   err      out  1                 with ack: address >= DEPTH
//   rdata    out  DATA_W            with ack: read data (store data on a write)
//   busy     out  1                 sequencer not in IDLE
// Requires ADDR_W < DATA_W.
module tcpu_mem_arbiter
  import tcpu_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              we,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata,
  output logic [NUM_PORTS-1:0]              ack,
  output logic                              err,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t                 state;
  port_idx_t              last;
  logic [NUM_PORTS-1:0]   grant;
  port_idx_t              grant_idx;
  logic [DATA_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   sel_we;

  logic [NUM_PORTS-1:0]   grant_p0;
  logic                   we_p0;
  logic [DATA_W-1:0]      addr_p0;
  logic [DATA_W-1:0]      wdata_p0;
  logic                   in_range_p0;

  logic [DATA_W-1:0]      mem [DEPTH];

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .req       (req),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Winner's request fields; non-winning ports never reach the datapath.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_addr  = addr[p];
        sel_wdata = wdata[p];
        sel_we    = we[p];
      end
    end
  end

  // ---- stage p0: request captured in IDLE, consumed in ACCESS ----
  always_ff @(posedge clk) begin
    if (state == IDLE && |req) begin
      grant_p0 <= grant;
      we_p0    <= sel_we;
      addr_p0  <= sel_addr;
      wdata_p0 <= sel_wdata;
    end
  end

  assign in_range_p0 = (addr_p0[DATA_W-1:ADDR_W] == '0);

  // Array is deliberately unreset. Reset forces state to IDLE
  // asynchronously, so a pending store never reaches the ACCESS edge.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_p0 && in_range_p0) begin
      mem[addr_p0[ADDR_W-1:0]] <= wdata_p0;
    end
  end

  // ---- stage p1: sequencer and registered outputs ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= port_idx_t'(NUM_PORTS - 1);
      ack   <= '0;
      err   <= 1'b0;
      rdata <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= ACCESS;
            last  <= grant_idx;
            busy  <= 1'b1;
          end
        end
        ACCESS: begin
          state <= DONE;
          ack   <= grant_p0;
          if (!in_range_p0) begin
            err   <= 1'b1;
            rdata <= '0;
          end else if (we_p0) begin
            rdata <= wdata_p0;
          end else begin
            rdata <= mem[addr_p0[ADDR_W-1:0]];
          end
        end
        DONE: begin
          state <= IDLE;
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcpu_mem_arbiter.sv
// Testbench for tcpu_mem_arbiter: a 2-port instance driven through a
// scoreboard, plus a 4-port instance for the fairness bound.
module tb_tcpu_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;

  logic [1:0]        req, we, ack;
  logic [1:0][15:0]  addr, wdata;
  logic              err, busy;
  logic [15:0]       rdata;

  logic [3:0]        req4, we4, ack4;
  logic [3:0][15:0]  addr4, wdata4;
  logic              err4, busy4;
  logic [15:0]       rdata4;

  typedef struct packed {
    logic [2:0]  port;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [16];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  tcpu_mem_arbiter #(.NUM_PORTS(2), .DATA_W(16), .ADDR_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy)
  );

  tcpu_mem_arbiter #(.NUM_PORTS(4), .DATA_W(16), .ADDR_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .we(we4), .addr(addr4),
    .wdata(wdata4), .ack(ack4), .err(err4), .rdata(rdata4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected result of one access on the 2-port instance, updating the model.
  function automatic exp_t predict(input int port, input logic w,
                                   input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.port = 3'(port);
    if (a[15:4] != 12'h000) begin
      e.err   = 1'b1;
      e.rdata = 16'h0000;
    end else if (w) begin
      model[a[3:0]] = d;
      e.err   = 1'b0;
      e.rdata = d;
    end else begin
      e.err   = 1'b0;
      e.rdata = model[a[3:0]];
    end
    return e;
  endfunction

  // Scoreboard consumer: every ack pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && ack !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {30'd0, ack}, 32'd1 << e.port);
        check("err", {31'd0, err}, {31'd0, e.err});
        check("rdata", {16'd0, rdata}, {16'd0, e.rdata});
      end
    end
  end

  // Single uncontended access: ack expected two negedges after req.
  task automatic do_access(input int port, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
    int lat;
    bit seen;
    @(negedge clk);
    req[port]   = 1'b1;
    we[port]    = w;
    addr[port]  = a;
    wdata[port] = d;
    sb.push_back(predict(port, w, a, d));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack[port]) seen = 1'b1;
    end
    check("ack_latency", lat, 2);
    req[port] = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {30'd0, ack}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Both ports read continuously for `rounds` grants; checks the 3-cycle rhythm.
  task automatic run_pair(input logic [15:0] a0, input logic [15:0] a1, input int rounds);
    @(negedge clk);
    we      = 2'b00;
    addr[0] = a0;
    addr[1] = a1;
    req     = 2'b11;
    for (int r = 0; r < rounds; r++) begin
      sb.push_back(predict(r % 2, 1'b0, (r % 2 == 0) ? a0 : a1, 16'h0000));
    end
    for (int n = 1; n <= 3 * rounds; n++) begin
      @(negedge clk);
      check("pair_busy", {31'd0, busy}, {31'd0, (n % 3) != 0});
      check("pair_ack_slot", {31'd0, |ack}, {31'd0, (n % 3) == 2});
      if (n == 3 * rounds - 1) req = 2'b00;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_busy_after", {31'd0, busy}, 32'd0);

    // Write then read-back on the loader port.
    do_access(1, 1'b1, 16'h0003, 16'hBEEF);
    do_access(1, 1'b0, 16'h0003, 16'h0000);

    // Contention from reset: grants alternate starting with port 0.
    do_access(1, 1'b1, 16'h0000, 16'hA0A0);
    do_access(1, 1'b1, 16'h0001, 16'h0B0B);
    pulse_reset();
    run_pair(16'h0000, 16'h0001, 4);

    // Out-of-range store is rejected and leaves mem[0] intact.
    do_access(0, 1'b1, 16'h0010, 16'h1234);
    do_access(0, 1'b0, 16'h0000, 16'h0000);

    // Reset while a store to 0x0005 sits in ACCESS.
    do_access(0, 1'b1, 16'h0005, 16'h1111);
    do_access(1, 1'b1, 16'h0002, 16'h2222);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 16'h5555;
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", {30'd0, ack}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_rdata", {16'd0, rdata}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_pair(16'h0005, 16'h0003, 2);

    // Loader downloads a program; CPU-side fetches it, then stores its result.
    for (int i = 0; i < 10; i++) do_access(1, 1'b1, 16'(i), 16'h7000 + 16'(i * 16'h0101));
    for (int i = 0; i < 10; i++) do_access(0, 1'b0, 16'(i), 16'h0000);
    do_access(0, 1'b1, 16'h0000, 16'h0046);
    do_access(1, 1'b0, 16'h0000, 16'h0000);

    // Four continuous requesters: served 0,1,2,3 within 12 cycles.
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      addr4[p]  = 16'(p);
      wdata4[p] = 16'h0100 + 16'(p);
    end
    we4  = 4'hF;
    req4 = 4'hF;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n % 3 == 2) begin
        check("rr4_ack", {28'd0, ack4}, 32'd1 << (n / 3));
        check("rr4_rdata", {16'd0, rdata4}, 32'h0100 + (n / 3));
        check("rr4_err", {31'd0, err4}, 32'd0);
        req4[n / 3] = 1'b0;
      end else begin
        check("rr4_no_ack", {28'd0, ack4}, 32'd0);
      end
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
